// File: rtl/gemm_pkg.sv
// +----------------------------------------------------------------------------+
// | gemm_pkg: shared command types, opcodes and sizes for the GEMM controller. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package gemm_pkg;

  localparam int cmd_buf_width_gp = 32;

  typedef logic [7:0] cmd_op_s;

  localparam cmd_op_s CMD_OP_FETCH         = 8'hF0;
  localparam cmd_op_s CMD_OP_DISPATCH      = 8'hF1;
  localparam cmd_op_s CMD_OP_TILE          = 8'hF2;
  localparam cmd_op_s CMD_OP_WAIT_DISPATCH = 8'hF3;
  localparam cmd_op_s CMD_OP_WAIT_MATMUL   = 8'hF4;
  localparam cmd_op_s CMD_OP_READOUT       = 8'hF5;

  // Payload lengths in FIFO words
  localparam int cmd_fetch_len_gp    = 3;
  localparam int cmd_dispatch_len_gp = 3;
  localparam int cmd_tile_len_gp     = 3;
  localparam int cmd_wait_len_gp     = 1;
  localparam int cmd_readout_len_gp  = 2;

  typedef struct packed {
    logic [31:0] w2;
    logic [31:0] w1;
    logic [31:0] w0;
  } cmd_tile_s;

  localparam int cmd_payload_max_width_gp = $bits(cmd_tile_s);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_PAY   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4
  } cmd_seq_state_e;

  // Zero marks an unknown opcode
  function automatic logic [5:0] cmd_exp_words(input cmd_op_s op);
    logic [5:0] n;
    n = 6'd0;
    case (op)
      CMD_OP_FETCH:         n = 6'(cmd_fetch_len_gp);
      CMD_OP_DISPATCH:      n = 6'(cmd_dispatch_len_gp);
      CMD_OP_TILE:          n = 6'(cmd_tile_len_gp);
      CMD_OP_WAIT_DISPATCH: n = 6'(cmd_wait_len_gp);
      CMD_OP_WAIT_MATMUL:   n = 6'(cmd_wait_len_gp);
      CMD_OP_READOUT:       n = 6'(cmd_readout_len_gp);
      default:              n = 6'd0;
    endcase
    return n;
  endfunction

  // Engine select: bit0 fetch, bit1 dispatch, bit2 tile, bit3 readout
  function automatic logic [3:0] cmd_engine_sel(input cmd_op_s op);
    logic [3:0] s;
    s = 4'b0000;
    case (op)
      CMD_OP_FETCH:    s = 4'b0001;
      CMD_OP_DISPATCH: s = 4'b0010;
      CMD_OP_TILE:     s = 4'b0100;
      CMD_OP_READOUT:  s = 4'b1000;
      default:         s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_done_tracker.sv
// +----------------------------------------------------------------------------+
// | cmd_done_tracker: remembers the last completed id of one engine and flags  |
// | when a requested wait id has completed (now or earlier). Rev 1.0           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module cmd_done_tracker (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       done_i,
  input  logic [7:0] done_id_i,
  input  logic [7:0] wait_id_i,
  output logic       match_o
);

  logic [7:0] last_id_q;
  logic       last_vld_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_id_q  <= 8'd0;
      last_vld_q <= 1'b0;
    end else if (done_i) begin
      last_id_q  <= done_id_i;
      last_vld_q <= 1'b1;
    end
  end

  assign match_o = (done_i && (done_id_i == wait_id_i)) ||
                   (last_vld_q && (last_id_q == wait_id_i));

endmodule

`default_nettype wire

// File: rtl/cmd_sequencer.sv
// +----------------------------------------------------------------------------+
// | cmd_sequencer: assembles FIFO words into commands, issues them to engines  |
// | and executes waits. Optional macro CMD_SEQ_LEN_CHECK_EN. Rev 1.0          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module cmd_sequencer
  import gemm_pkg::*;
#(
  parameter int CMD_W     = 32,
  parameter int PAYLOAD_W = 96
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [CMD_W-1:0]     i_cmd_data,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  output logic [7:0]           o_cmd_op,
  output logic [7:0]           o_cmd_id,
  output logic [PAYLOAD_W-1:0] o_cmd_payload,
  output logic                 o_fetch_valid,
  input  logic                 i_fetch_ready,
  output logic                 o_disp_valid,
  input  logic                 i_disp_ready,
  output logic                 o_tile_valid,
  input  logic                 i_tile_ready,
  output logic                 o_rd_valid,
  input  logic                 i_rd_ready,
  input  logic                 i_disp_done,
  input  logic [7:0]           i_disp_done_id,
  input  logic                 i_tile_done,
  input  logic [7:0]           i_tile_done_id,
  output logic                 o_busy,
  output logic                 o_err,
  output logic [7:0]           o_err_op,
  input  logic                 i_err_clr
);

  cmd_seq_state_e         state_q;
  logic [5:0]             cnt_q;
  logic [1:0]             idx_q;
  logic [7:0]             op_q;
  logic [7:0]             id_q;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic [3:0]             vld_q;
  logic                   err_q;
  logic [7:0]             err_op_q;

  logic       cmd_fire;
  logic [5:0] hdr_exp;
  logic [5:0] hdr_len_words;
  logic       hdr_bad;
  logic       hdr_fault;
  logic       issue_fire;
  logic       disp_match;
  logic       tile_match;
  logic       wait_ok;

  assign o_cmd_ready   = i_reset_n &&
                         ((state_q == S_HDR) || (state_q == S_PAY) || (state_q == S_DRAIN));
  assign cmd_fire      = o_cmd_ready && i_cmd_valid;
  assign hdr_exp       = cmd_exp_words(i_cmd_data[7:0]);
  assign hdr_len_words = i_cmd_data[23:18];

`ifdef CMD_SEQ_LEN_CHECK_EN
  assign hdr_bad = (hdr_exp == 6'd0) || (i_cmd_data[23:16] != {hdr_exp, 2'b00});
`else
  assign hdr_bad = (hdr_exp == 6'd0);
`endif

  assign hdr_fault  = (state_q == S_HDR) && cmd_fire && hdr_bad;
  assign issue_fire = |(vld_q & {i_rd_ready, i_tile_ready, i_disp_ready, i_fetch_ready});
  assign wait_ok    = (op_q == CMD_OP_WAIT_MATMUL) ? tile_match : disp_match;

  cmd_done_tracker u_disp_trk (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .done_i    (i_disp_done),
    .done_id_i (i_disp_done_id),
    .wait_id_i (payload_q[7:0]),
    .match_o   (disp_match)
  );

  cmd_done_tracker u_tile_trk (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .done_i    (i_tile_done),
    .done_id_i (i_tile_done_id),
    .wait_id_i (payload_q[7:0]),
    .match_o   (tile_match)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_HDR;
      cnt_q     <= 6'd0;
      idx_q     <= 2'd0;
      op_q      <= 8'd0;
      id_q      <= 8'd0;
      payload_q <= '0;
      vld_q     <= 4'b0000;
      err_q     <= 1'b0;
      err_op_q  <= 8'd0;
    end else begin
      case (state_q)
        S_HDR: begin
          if (cmd_fire) begin
            op_q      <= i_cmd_data[7:0];
            id_q      <= i_cmd_data[15:8];
            payload_q <= '0;
            idx_q     <= 2'd0;
            if (hdr_bad) begin
              cnt_q   <= hdr_len_words;
              state_q <= (hdr_len_words == 6'd0) ? S_HDR : S_DRAIN;
            end else begin
              cnt_q   <= hdr_exp;
              state_q <= S_PAY;
            end
          end
        end
        S_PAY: begin
          if (cmd_fire) begin
            payload_q[idx_q*CMD_W +: CMD_W] <= i_cmd_data;
            idx_q <= idx_q + 2'd1;
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
              if ((op_q == CMD_OP_WAIT_DISPATCH) || (op_q == CMD_OP_WAIT_MATMUL)) begin
                state_q <= S_WAIT;
              end else begin
                vld_q   <= cmd_engine_sel(op_q);
                state_q <= S_ISSUE;
              end
            end
          end
        end
        S_ISSUE: begin
          if (issue_fire) begin
            vld_q   <= 4'b0000;
            state_q <= S_HDR;
          end
        end
        S_WAIT: begin
          if (wait_ok) state_q <= S_HDR;
        end
        S_DRAIN: begin
          if (cmd_fire) begin
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) state_q <= S_HDR;
          end
        end
        default: state_q <= S_HDR;
      endcase

      // A new fault overrides a simultaneous clear
      if (hdr_fault) begin
        if (!err_q || i_err_clr) begin
          err_q    <= 1'b1;
          err_op_q <= i_cmd_data[7:0];
        end
      end else if (i_err_clr) begin
        err_q    <= 1'b0;
        err_op_q <= 8'd0;
      end
    end
  end

  assign o_cmd_op      = op_q;
  assign o_cmd_id      = id_q;
  assign o_cmd_payload = payload_q;
  assign o_fetch_valid = vld_q[0];
  assign o_disp_valid  = vld_q[1];
  assign o_tile_valid  = vld_q[2];
  assign o_rd_valid    = vld_q[3];
  assign o_busy        = (state_q != S_HDR);
  assign o_err         = err_q;
  assign o_err_op      = err_op_q;

endmodule

`default_nettype wire
